// File: rtl/alu_sweep_checker_pkg.sv
// Shared definitions for the ALU sweep checker and the 4-bit ALU tile it exercises.
// Opcode values must stay in step with the ALU tile's decoder.
package alu_sweep_checker_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    localparam int unsigned IDX_W      = 10;
    localparam int unsigned IDX_A_LSB  = 0;
    localparam int unsigned IDX_B_LSB  = 4;
    localparam int unsigned IDX_OP_LSB = 8;
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/alu_sweep_checker_golden.sv
// Combinational reference for the 4-bit ALU tile: (a, b, op) -> 8-bit expected result.
// Kept standalone so testbenches can reuse it.
module alu_golden_model
    import alu_sweep_checker_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] op,
    output logic [7:0] expected
);

    always_comb begin
        expected = '0;
        case (op)
            OP_ADD:  expected = {4'b0000, a} + {4'b0000, b};
            OP_SUB:  expected = {4'b0000, a} - {4'b0000, b};
            OP_AND:  expected = {4'b0000, a & b};
            OP_OR:   expected = {4'b0000, a | b};
            default: expected = '0;
        endcase
    end

endmodule

// File: rtl/alu_sweep_checker.sv
// Exhaustive self-test initiator for the 4-bit ALU tile: sweeps all 1024 vectors,
// compares each settled result with the golden model and reports the outcome.
module alu_sweep_checker
    import alu_sweep_checker_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_op,
    input  logic [7:0]       alu_result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [9:0]       first_fail,
    output logic [7:0]       first_got
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               fail_seen_q, fail_seen_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [IDX_W-1:0]   ff_q, ff_d;
    logic [7:0]         fg_q, fg_d;
    logic [7:0]         expected;
    logic               mismatch;

    alu_golden_model u_golden (
        .a        (idx_q[IDX_A_LSB +: 4]),
        .b        (idx_q[IDX_B_LSB +: 4]),
        .op       (idx_q[IDX_OP_LSB +: 2]),
        .expected (expected)
    );

    assign mismatch = (alu_result != expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            err_q       <= '0;
            fail_seen_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            ff_q        <= '0;
            fg_q        <= '0;
        end else if (ena) begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            fail_seen_q <= fail_seen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            ff_q        <= ff_d;
            fg_q        <= fg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        fail_seen_d = fail_seen_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        ff_d        = ff_q;
        fg_d        = fg_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_SETTLE;
                    idx_d       = '0;
                    cnt_d       = '0;
                    err_d       = '0;
                    fail_seen_d = 1'b0;
                    ff_d        = '0;
                    fg_d        = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_q != '1) err_d = err_q + ERR_W'(1);
                    if (!fail_seen_q) begin
                        ff_d        = idx_q;
                        fg_d        = alu_result;
                        fail_seen_d = 1'b1;
                    end
                end
                // pass uses the post-increment count so the last vector is included
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign alu_a      = idx_q[IDX_A_LSB +: 4];
    assign alu_b      = idx_q[IDX_B_LSB +: 4];
    assign alu_op     = idx_q[IDX_OP_LSB +: 2];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign first_got  = fg_q;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Scoreboard bench for alu_sweep_checker: a behavioural ALU with selectable faults drives
// the checker; each start pushes the expected sweep outcome, a monitor compares on done.
module tb_alu_sweep_checker;

    localparam int S   = 1;
    localparam int LAT = 1024 * (S + 1) + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic       start4 = 1'b0;

    logic [3:0] alu_a, alu_b, alu_a4, alu_b4;
    logic [1:0] alu_op, alu_op4;
    logic [7:0] alu_result, alu_result4;
    logic       busy, done, pass, busy4, done4, pass4;
    logic [7:0] err_count;
    logic [3:0] err_count4;
    logic [9:0] first_fail, first_fail4;
    logic [7:0] first_got, first_got4;

    int mode = 0;
    int bad_idx = 0;
    int flip = 0;
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int err;
        int ff;
        int fg;
        int ps;
        int lat;
        int t0;
    } exp_t;

    exp_t sb[$];
    exp_t sb4[$];
    exp_t mon_e, mon_e4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_golden(input int a, input int b, input int op);
        case (op)
            0:       return 8'(a + b);
            1:       return 8'((a - b + 256) % 256);
            2:       return 8'(a & b);
            default: return 8'(a | b);
        endcase
    endfunction

    // mode 0 correct, 1 sub answers a+b, 2 stuck at zero, 3 one vector corrupted
    function automatic logic [7:0] bench_alu(input int m, input int i, input int bad, input int flp);
        int a, b, op;
        a  = i % 16;
        b  = (i / 16) % 16;
        op = i / 256;
        case (m)
            0:       return ref_golden(a, b, op);
            1:       return (op == 1) ? 8'(a + b) : ref_golden(a, b, op);
            2:       return 8'h00;
            default: return (i == bad) ? (ref_golden(a, b, op) ^ 8'(flp)) : ref_golden(a, b, op);
        endcase
    endfunction

    function automatic exp_t ref_sweep(input int m, input int bad, input int flp, input int errw, input int extra);
        exp_t e;
        int   got, want, maxv;
        bit   first;
        e.err = 0; e.ff = 0; e.fg = 0; e.t0 = 0;
        first = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            got  = int'(bench_alu(m, i, bad, flp));
            want = int'(ref_golden(i % 16, (i / 16) % 16, i / 256));
            if (got != want) begin
                e.err++;
                if (first) begin
                    e.ff  = i;
                    e.fg  = got;
                    first = 1'b0;
                end
            end
        end
        e.ps = (e.err == 0) ? 1 : 0;
        maxv = (1 << errw) - 1;
        if (e.err > maxv) e.err = maxv;
        e.lat = LAT + extra;
        return e;
    endfunction

    assign alu_result  = bench_alu(mode, int'({alu_op, alu_b, alu_a}), bad_idx, flip);
    assign alu_result4 = 8'h00;

    alu_sweep_checker #(.SETTLE_CYCLES(S), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail(first_fail), .first_got(first_got)
    );

    alu_sweep_checker #(.SETTLE_CYCLES(S), .ERR_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4), .alu_result(alu_result4),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err_count4),
        .first_fail(first_fail4), .first_got(first_got4)
    );

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at cyc=%0d", nm, got, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vec"}, int'({alu_op, alu_b, alu_a}), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_err"}, int'(err_count), 0);
        chk({tag, "_ff"}, int'(first_fail), 0);
        chk({tag, "_fg"}, int'(first_got), 0);
    endtask

    logic done_seen = 1'b0;
    logic done4_seen = 1'b0;

    always @(negedge clk) begin
        if (done && !done_seen) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("err_count", int'(err_count), mon_e.err);
                chk("first_fail", int'(first_fail), mon_e.ff);
                chk("first_got", int'(first_got), mon_e.fg);
                chk("pass", int'(pass), mon_e.ps);
                chk("busy_at_done", int'(busy), 0);
                chk("latency", cyc - mon_e.t0, mon_e.lat);
            end
        end
        if (done4 && !done4_seen) begin
            if (sb4.size() == 0) begin
                chk("unexpected_done4", 1, 0);
            end else begin
                mon_e4 = sb4.pop_front();
                chk("err_count4", int'(err_count4), mon_e4.err);
                chk("first_fail4", int'(first_fail4), mon_e4.ff);
                chk("first_got4", int'(first_got4), mon_e4.fg);
                chk("pass4", int'(pass4), mon_e4.ps);
                chk("latency4", cyc - mon_e4.t0, mon_e4.lat);
            end
        end
        done_seen  = done;
        done4_seen = done4;
    end

    task automatic issue(input int m, input int bad, input int flp, input int extra, output int t0);
        exp_t e;
        @(negedge clk);
        mode    = m;
        bad_idx = bad;
        flip    = flp;
        start   = 1'b1;
        t0      = cyc;
        e       = ref_sweep(m, bad, flp, 8, extra);
        e.t0    = t0;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sb(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    function automatic int sweep_idx(input int t0);
        return (cyc - t0 - 1) / (S + 1);
    endfunction

    initial begin
        int   t0, r, r2, snap, n;
        exp_t e4;

        repeat (3) @(negedge clk);
        chk_zero("reset");
        chk("reset_busy4", int'(busy4), 0);
        chk("reset_err4", int'(err_count4), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // correct ALU, plus vector drive check at idx 500
        issue(0, 0, 0, 0, t0);
        chk("busy_after_start", int'(busy), 1);
        wait_to(t0 + 1001);
        chk("vec_at_500", int'({alu_op, alu_b, alu_a}), 500);
        wait_sb(LAT + 50);

        // restart from DONE with sub fault
        chk("done_before_restart", int'(done), 1);
        issue(1, 0, 0, 0, t0);
        chk("restart_done", int'(done), 0);
        chk("restart_pass", int'(pass), 0);
        chk("restart_err", int'(err_count), 0);
        chk("restart_busy", int'(busy), 1);
        wait_sb(LAT + 50);

        // single random corrupted vectors
        for (int k = 0; k < 2; k++) begin
            issue(3, int'($urandom_range(0, 1023)), int'($urandom_range(1, 255)), 0, t0);
            wait_sb(LAT + 50);
        end

        // start re-pulse mid-sweep is ignored; ena low for 10 cycles stretches the sweep
        issue(0, 0, 0, 10, t0);
        r = int'($urandom_range(10, 600));
        wait_to(t0 + r);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("repulse_idx", int'({alu_op, alu_b, alu_a}), sweep_idx(t0));
        @(negedge clk);
        chk("repulse_idx_next", int'({alu_op, alu_b, alu_a}), sweep_idx(t0));
        r2 = int'($urandom_range(r + 20, 1800));
        wait_to(t0 + r2);
        ena  = 1'b0;
        snap = int'({alu_op, alu_b, alu_a});
        repeat (10) @(negedge clk);
        chk("ena_hold_idx", int'({alu_op, alu_b, alu_a}), snap);
        chk("ena_hold_busy", int'(busy), 1);
        ena = 1'b1;
        wait_sb(LAT + 60);

        // asynchronous reset mid-sweep
        issue(0, 0, 0, 0, t0);
        wait_to(t0 + 1001);
        chk("vec_before_reset", int'({alu_op, alu_b, alu_a}), 500);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset_busy", int'(busy), 0);
        issue(0, 0, 0, 0, t0);
        wait_sb(LAT + 50);

        // ERR_W=4, stuck-at-zero ALU
        @(negedge clk);
        start4 = 1'b1;
        e4     = ref_sweep(2, 0, 0, 4, 0);
        e4.t0  = cyc;
        sb4.push_back(e4);
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (sb4.size() != 0 && n < LAT + 50) begin
            @(negedge clk);
            n++;
        end
        if (sb4.size() != 0) begin
            chk("done4_timeout", 0, 1);
            sb4.delete();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
